// File: rtl/net_pkg.sv
// Shared types for the network transmit arbiter: FSM states, grant owner
// and the default inter-frame gap.
package net_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARP  = 2'd1,
    ST_UDP  = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_ARP = 1'b0,
    GNT_UDP = 1'b1
  } grant_t;

  localparam int DEFAULT_IFG = 12;

endpackage

// File: rtl/net_tx_slice.sv
// Single-stage 8-bit + last register slice toward the MAC. The upstream ready
// depends only on this stage's occupancy and the MAC ready, never on in_valid.
module net_tx_slice (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
);

  logic [7:0] data_p1;
  logic       vld_p1;
  logic       last_p1;

  assign in_ready = !vld_p1 || out_ready;

  // stage p1: output register, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        data_p1 <= in_data;
        last_p1 <= in_last;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign out_last  = last_p1;

endmodule

// File: rtl/net_tx_arb.sv
// Round-robin ARP/UDP frame arbiter feeding one MAC stream, with a locked grant
// per frame, an inter-frame gap and per-source frame counters.
module net_tx_arb
  import net_pkg::*;
#(
  parameter int IFG_CYCLES = DEFAULT_IFG,
  parameter int CNT_W      = 16
) (
  input  logic             logic_clk,
  input  logic             logic_rst,
  input  logic [7:0]       arp_tdata_in,
  input  logic             arp_tvalid_in,
  input  logic             arp_tlast_in,
  output logic             arp_tready_out,
  input  logic [7:0]       udp_tdata_in,
  input  logic             udp_tvalid_in,
  input  logic             udp_tlast_in,
  output logic             udp_tready_out,
  output logic [7:0]       net_tdata_out,
  output logic             net_tvalid_out,
  output logic             net_tlast_out,
  input  logic             net_tready_in,
  output logic [CNT_W-1:0] arp_frame_cnt_out,
  output logic [CNT_W-1:0] udp_frame_cnt_out,
  output logic             arb_busy_out
);

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;

  logic [1:0]       rst_sync;
  logic             rst_n;
  arb_state_t       state;
  arb_state_t       state_nxt;
  grant_t           last_grant;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       sel_data;
  logic             sel_valid;
  logic             sel_last;
  logic             slice_ready;
  logic             arp_done;
  logic             udp_done;

  // Assertion is immediate; release is retimed through two flops.
  always_ff @(posedge logic_clk or negedge logic_rst) begin
    if (!logic_rst) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    case (state)
      ST_ARP: begin
        sel_data  = arp_tdata_in;
        sel_valid = arp_tvalid_in;
        sel_last  = arp_tlast_in;
      end
      ST_UDP: begin
        sel_data  = udp_tdata_in;
        sel_valid = udp_tvalid_in;
        sel_last  = udp_tlast_in;
      end
      default: ;
    endcase
  end

  assign arp_tready_out = (state == ST_ARP) && slice_ready;
  assign udp_tready_out = (state == ST_UDP) && slice_ready;
  assign arp_done       = arp_tvalid_in && arp_tready_out && arp_tlast_in;
  assign udp_done       = udp_tvalid_in && udp_tready_out && udp_tlast_in;
  assign arb_busy_out   = (state != ST_IDLE);

  always_ff @(posedge logic_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (arp_tvalid_in && (!udp_tvalid_in || last_grant == GNT_UDP))
          state_nxt = ST_ARP;
        else if (udp_tvalid_in)
          state_nxt = ST_UDP;
      end
      ST_ARP: if (arp_done) state_nxt = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_UDP: if (udp_done) state_nxt = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP: if (gap_cnt == '0 && !net_tvalid_out) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The gap only counts once the final byte has left the output register.
  always_ff @(posedge logic_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_UDP;
      gap_cnt    <= '0;
    end else begin
      if (state == ST_IDLE && state_nxt == ST_ARP) last_grant <= GNT_ARP;
      if (state == ST_IDLE && state_nxt == ST_UDP) last_grant <= GNT_UDP;
      if (state != ST_GAP && state_nxt == ST_GAP)
        gap_cnt <= GAP_LOAD;
      else if (state == ST_GAP && !net_tvalid_out && gap_cnt != '0)
        gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  always_ff @(posedge logic_clk or negedge rst_n) begin
    if (!rst_n) begin
      arp_frame_cnt_out <= '0;
      udp_frame_cnt_out <= '0;
    end else begin
      if (arp_done) arp_frame_cnt_out <= arp_frame_cnt_out + CNT_W'(1);
      if (udp_done) udp_frame_cnt_out <= udp_frame_cnt_out + CNT_W'(1);
    end
  end

  net_tx_slice u_slice (
    .clk       (logic_clk),
    .rst_n     (rst_n),
    .in_data   (sel_data),
    .in_valid  (sel_valid),
    .in_last   (sel_last),
    .in_ready  (slice_ready),
    .out_data  (net_tdata_out),
    .out_valid (net_tvalid_out),
    .out_last  (net_tlast_out),
    .out_ready (net_tready_in)
  );

endmodule

// File: tb/tb_net_tx_arb.sv
// Bench for net_tx_arb: expected frame order queue plus per-cycle rule checks
// on a default instance, and directed checks on an IFG=0 / CNT_W=4 instance.
module tb_net_tx_arb;

  localparam int IFG = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Instance A: default parameters
  logic        rst_n;
  logic [7:0]  arp_tdata, udp_tdata, net_tdata;
  logic        arp_tvalid, arp_tlast, arp_tready;
  logic        udp_tvalid, udp_tlast, udp_tready;
  logic        net_tvalid, net_tlast, net_tready;
  logic [15:0] arp_cnt, udp_cnt;
  logic        busy;

  net_tx_arb #(.IFG_CYCLES(IFG), .CNT_W(16)) dut (
    .logic_clk(clk), .logic_rst(rst_n),
    .arp_tdata_in(arp_tdata), .arp_tvalid_in(arp_tvalid), .arp_tlast_in(arp_tlast),
    .arp_tready_out(arp_tready),
    .udp_tdata_in(udp_tdata), .udp_tvalid_in(udp_tvalid), .udp_tlast_in(udp_tlast),
    .udp_tready_out(udp_tready),
    .net_tdata_out(net_tdata), .net_tvalid_out(net_tvalid), .net_tlast_out(net_tlast),
    .net_tready_in(net_tready),
    .arp_frame_cnt_out(arp_cnt), .udp_frame_cnt_out(udp_cnt), .arb_busy_out(busy)
  );

  // Instance B: no gap, 4-bit counters
  logic        b_rst;
  logic [7:0]  b_arp_tdata, b_udp_tdata, b_net_tdata;
  logic        b_arp_tvalid, b_arp_tlast, b_arp_tready;
  logic        b_udp_tvalid, b_udp_tlast, b_udp_tready;
  logic        b_net_tvalid, b_net_tlast, b_net_tready;
  logic [3:0]  b_arp_cnt, b_udp_cnt;
  logic        b_busy;

  net_tx_arb #(.IFG_CYCLES(0), .CNT_W(4)) dut_b (
    .logic_clk(clk), .logic_rst(b_rst),
    .arp_tdata_in(b_arp_tdata), .arp_tvalid_in(b_arp_tvalid), .arp_tlast_in(b_arp_tlast),
    .arp_tready_out(b_arp_tready),
    .udp_tdata_in(b_udp_tdata), .udp_tvalid_in(b_udp_tvalid), .udp_tlast_in(b_udp_tlast),
    .udp_tready_out(b_udp_tready),
    .net_tdata_out(b_net_tdata), .net_tvalid_out(b_net_tvalid), .net_tlast_out(b_net_tlast),
    .net_tready_in(b_net_tready),
    .arp_frame_cnt_out(b_arp_cnt), .udp_frame_cnt_out(b_udp_cnt), .arb_busy_out(b_busy)
  );

  // Model: expected output byte order, per-source completed frame counts
  typedef struct packed {logic src; logic [7:0] d; logic last;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   model_cnt[2];
  int   sent[2];
  logic chk_en = 1'b1;
  bit   after_last = 0;
  int   idle_run = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_d;
  logic prev_l;
  bit   done;

  task automatic expect_frame(input bit src, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++)
      exp_q.push_back('{src: src, d: base + 8'(i), last: (i == len - 1)});
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_outputs_zero", {net_tvalid, net_tlast, net_tdata, arp_tready, udp_tready,
                                  busy, |arp_cnt, |udp_cnt}, 0);
      exp_q.delete();
      model_cnt[0] = 0;
      model_cnt[1] = 0;
      after_last = 0;
      prev_stall = 0;
      idle_run = 0;
    end else begin
      check("ready_exclusive", arp_tready & udp_tready, 0);
      if (prev_stall) begin
        check("stall_valid", net_tvalid, 1);
        check("stall_data", net_tdata, prev_d);
        check("stall_last", net_tlast, prev_l);
      end
      if (net_tvalid) begin
        if (after_last) check("ifg_min", idle_run >= IFG, 1);
        after_last = 0;
      end else if (after_last) begin
        idle_run++;
        if (idle_run <= IFG) begin
          check("gap_busy", busy, 1);
          check("gap_readies", arp_tready | udp_tready, 0);
        end else if (idle_run == IFG + 1) begin
          check("gap_end_idle", busy, 0);
        end
      end
      if (net_tvalid && net_tready && chk_en) begin
        if (exp_q.size() == 0) begin
          check("out_byte_expected", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", net_tdata, e.d);
          check("out_last", net_tlast, e.last);
          if (e.last) begin
            model_cnt[e.src]++;
            check(e.src ? "udp_cnt" : "arp_cnt", e.src ? udp_cnt : arp_cnt, model_cnt[e.src]);
          end
        end
      end
      if (net_tvalid && net_tready && net_tlast) begin
        after_last = 1;
        idle_run = 0;
      end
      prev_stall = net_tvalid && !net_tready;
      prev_d = net_tdata;
      prev_l = net_tlast;
    end
  end

  task automatic drive(input bit src, input bit v, input logic [7:0] d, input bit l);
    if (src) begin udp_tvalid = v; udp_tdata = d; udp_tlast = l; end
    else     begin arp_tvalid = v; arp_tdata = d; arp_tlast = l; end
  endtask

  // Called #1 after a rising edge; returns at the same phase.
  task automatic send_frame(input bit src, input int len, input logic [7:0] base, input int bubble_at);
    bit hs;
    int w;
    for (int i = 0; i < len; i++) begin
      if (bubble_at > 0 && i == bubble_at) begin
        drive(src, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
      end
      drive(src, 1'b1, base + 8'(i), i == len - 1);
      w = 0;
      hs = 0;
      while (!hs) begin
        @(negedge clk);
        if (!rst_n) begin
          drive(src, 1'b0, 8'h00, 1'b0);
          return;
        end
        hs = src ? udp_tready : arp_tready;
        @(posedge clk);
        #1;
        w++;
        if (!hs && w > 500) begin
          check("driver_timeout", 0, 1);
          drive(src, 1'b0, 8'h00, 1'b0);
          return;
        end
      end
      sent[src]++;
    end
    drive(src, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic b_send1(input bit src, input logic [7:0] d);
    bit hs;
    int w;
    if (src) begin b_udp_tvalid = 1'b1; b_udp_tdata = d; b_udp_tlast = 1'b1; end
    else     begin b_arp_tvalid = 1'b1; b_arp_tdata = d; b_arp_tlast = 1'b1; end
    w = 0;
    hs = 0;
    while (!hs) begin
      @(negedge clk);
      hs = src ? b_udp_tready : b_arp_tready;
      @(posedge clk);
      #1;
      w++;
      if (!hs && w > 200) begin
        check("b_driver_timeout", 0, 1);
        return;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    b_rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    net_tready = 1'b1;
    b_arp_tvalid = 1'b0; b_arp_tdata = 8'h00; b_arp_tlast = 1'b0;
    b_udp_tvalid = 1'b0; b_udp_tdata = 8'h00; b_udp_tlast = 1'b0;
    b_net_tready = 1'b1;
    sent[0] = 0;
    sent[1] = 0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_valid", net_tvalid, 0);
    check("reset_b_valid", b_net_tvalid, 0);
    rst_n = 1'b1;
    b_rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // ARP-only 42-byte frame at full rate
    expect_frame(1'b0, 42, 8'h10);
    fork
      send_frame(1'b0, 42, 8'h10, 0);
      begin
        int t0, lat, run, tl;
        t0 = cyc;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (net_tvalid) begin
            lat = cyc - t0;
            break;
          end
        end
        check("t1_first_byte_latency", lat, 2);
        run = 0;
        tl = 0;
        while (net_tvalid && run < 100) begin
          run++;
          if (net_tlast) tl = run;
          @(negedge clk);
        end
        check("t1_contiguous_bytes", run, 42);
        check("t1_tlast_position", tl, 42);
      end
    join
    repeat (20) @(posedge clk);
    #1;
    check("t1_arp_cnt", arp_cnt, 1);
    check("t1_queue_drained", exp_q.size(), 0);

    // Simultaneous requests out of reset: ARP, UDP, then ARP again on the next tie
    pulse_reset();
    expect_frame(1'b0, 10, 8'h40);
    expect_frame(1'b1, 8, 8'h80);
    expect_frame(1'b0, 5, 8'h50);
    expect_frame(1'b1, 5, 8'h90);
    fork
      begin send_frame(1'b0, 10, 8'h40, 0); send_frame(1'b0, 5, 8'h50, 0); end
      begin send_frame(1'b1, 8, 8'h80, 0); send_frame(1'b1, 5, 8'h90, 0); end
      begin
        int t0, t1;
        t0 = cyc;
        t1 = -1;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (busy) begin
            t1 = cyc - t0;
            break;
          end
        end
        check("t2_first_grant_after_release", t1, 3);
      end
    join
    repeat (20) @(posedge clk);
    #1;
    check("t2_arp_cnt", arp_cnt, 2);
    check("t2_udp_cnt", udp_cnt, 2);
    check("t2_queue_drained", exp_q.size(), 0);

    // 64-byte UDP frame with the MAC ready toggling every cycle
    expect_frame(1'b1, 64, 8'h00);
    done = 0;
    fork
      begin send_frame(1'b1, 64, 8'h00, 0); done = 1; end
      begin
        while (!done) begin
          net_tready = ~net_tready;
          @(posedge clk);
          #1;
        end
      end
    join
    net_tready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t3_udp_cnt", udp_cnt, 3);
    check("t3_queue_drained", exp_q.size(), 0);

    // Reset in the middle of a 60-byte ARP frame
    chk_en = 1'b0;
    sent[0] = 0;
    fork
      send_frame(1'b0, 60, 8'h20, 0);
      begin
        for (int k = 0; k < 2000 && sent[0] < 20; k++) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_reached_byte20", sent[0] >= 20, 1);
        check("t4_rst_valid", net_tvalid, 0);
        check("t4_rst_data", net_tdata, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_arp_ready", arp_tready, 0);
        check("t4_rst_arp_cnt", arp_cnt, 0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Fresh ARP frame with a mid-frame stall, UDP competing the whole time
    expect_frame(1'b0, 6, 8'hC0);
    expect_frame(1'b1, 4, 8'hE0);
    fork
      send_frame(1'b0, 6, 8'hC0, 2);
      send_frame(1'b1, 4, 8'hE0, 0);
    join
    repeat (20) @(posedge clk);
    #1;
    check("t4_arp_cnt", arp_cnt, 1);
    check("t4_udp_cnt", udp_cnt, 1);
    check("t4_queue_drained", exp_q.size(), 0);

    // No-gap instance: back-to-back 1-byte UDP frames
    fork
      begin
        for (int k = 0; k < 4; k++) b_send1(1'b1, 8'hA0 + 8'(k));
        b_udp_tvalid = 1'b0;
        b_udp_tlast = 1'b0;
      end
      begin
        int prev_c, nseen;
        prev_c = -1;
        nseen = 0;
        for (int k = 0; k < 60 && nseen < 4; k++) begin
          @(negedge clk);
          if (b_net_tvalid) begin
            check("b_udp_data", b_net_tdata, 8'hA0 + 8'(nseen));
            check("b_udp_last", b_net_tlast, 1);
            check("b_udp_cnt", b_udp_cnt, 4'(nseen + 1));
            if (prev_c >= 0) check("b_udp_spacing", cyc - prev_c, 2);
            prev_c = cyc;
            nseen++;
          end
        end
        check("b_udp_frames_seen", nseen, 4);
      end
    join

    // 17 ARP frames wrap a 4-bit counter to 1
    for (int k = 0; k < 17; k++) b_send1(1'b0, 8'(k));
    b_arp_tvalid = 1'b0;
    b_arp_tlast = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("b_arp_cnt_wrap", b_arp_cnt, 1);
    check("b_udp_cnt_final", b_udp_cnt, 4);
    check("b_idle_after", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/net_tx_arb.md
NET_TX_ARB -- requirements
Module: net_tx_arb

Interface
REQ-001 Parameter IFG_CYCLES, default 12: idle output cycles inserted after each frame's last byte; 0 disables the gap.
REQ-002 Parameter CNT_W, default 16: width of the per-source frame counters.
REQ-003 logic_clk  input  1  single clock for all logic.
REQ-004 logic_rst  input  1  asynchronous reset, active-low.
REQ-005 arp_tdata_in/arp_tvalid_in/arp_tlast_in  input  8/1/1  ARP frame byte stream.
REQ-006 arp_tready_out  output  1  ARP stream accept.
REQ-007 udp_tdata_in/udp_tvalid_in/udp_tlast_in  input  8/1/1  UDP frame byte stream.
REQ-008 udp_tready_out  output  1  UDP stream accept.
REQ-009 net_tdata_out/net_tvalid_out/net_tlast_out  output  8/1/1  merged stream to MAC.
REQ-010 net_tready_in  input  1  MAC accept.
REQ-011 arp_frame_cnt_out/udp_frame_cnt_out  output  CNT_W each  frames forwarded per source.
REQ-012 arb_busy_out  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Transfer rule, all ports: a byte moves only when valid and ready are both high in the same cycle.
REQ-014 FSM states are IDLE, ARP, UDP and GAP.
REQ-015 IDLE to ARP: arp_tvalid_in=1 and (udp_tvalid_in=0 or last_grant=UDP).
REQ-016 IDLE to UDP: udp_tvalid_in=1 and (arp_tvalid_in=0 or last_grant=ARP).
REQ-017 The IDLE decision is registered; a grant takes effect the cycle after the request is seen.
REQ-018 last_grant updates on entry to ARP or UDP; the result is round-robin on simultaneous requests.
REQ-019 In ARP or UDP, only the granted input may receive ready=1; the other input's ready stays 0.
REQ-020 Granted ready = !net_tvalid_out | net_tready_in.
REQ-021 Single output register stage; each accepted input byte appears on the output the next cycle (latency 1).
REQ-022 Output register holds its data, valid and last unchanged while net_tvalid_out=1 and net_tready_in=0.
REQ-023 Grant stays locked until the granted input's tlast byte is accepted.
REQ-024 Then: go to GAP if IFG_CYCLES>0, else go to IDLE.
REQ-025 In GAP, a counter loads IFG_CYCLES-1 on entry and decrements while net_tvalid_out=0.
REQ-026 GAP to IDLE when the counter is 0 and net_tvalid_out=0, giving exactly IFG_CYCLES idle output cycles after the last byte leaves.
REQ-027 Both input readies are 0 in GAP and in IDLE.
REQ-028 A frame counter increments by 1 when its source's tlast byte is accepted, wrapping modulo 2^CNT_W.
REQ-029 A 1-byte frame (tvalid and tlast together) is legal and handled like any frame.
REQ-030 A request dropped while in IDLE causes no grant; a stalled source (tvalid=0 mid-frame) keeps the grant indefinitely.

Reset
REQ-031 While logic_rst=0, all outputs are held at 0 and the FSM is held in IDLE.
REQ-032 Reset also sets last_grant=UDP (so ARP wins the first tie) and clears the GAP counter.
REQ-033 Reset mid-frame discards the partial frame, with no recovery of stale bytes.
REQ-034 Reset release is synchronised internally by a two-flop release chain; the first grant is possible 3 cycles after release.

Structure
REQ-035 A shared package net_pkg holds the FSM state enum (IDLE/ARP/UDP/GAP), a grant enum (ARP/UDP) and a default IFG constant of 12.
REQ-036 One sub-module, net_tx_slice, implements the single-stage 8-bit+last register slice of REQ-020 to REQ-022.
REQ-037 The FSM, arbitration, gap counter and frame counters reside in net_tx_arb.

Verification
REQ-038 Scenario: ARP-only 42-byte frame, net_tready_in=1 -> 42 contiguous output bytes, first one 2 cycles after arp_tvalid_in rises, tlast on byte 42, then 12 idle cycles, arp_frame_cnt_out=1.
REQ-039 Scenario: ARP and UDP both valid out of reset -> ARP frame forwarded first, then UDP; next tie grants ARP; udp_tready_out stays 0 throughout ARP frames.
REQ-040 Scenario: net_tready_in toggling 1010... during a 64-byte UDP frame -> output byte order identical to input, no duplicates or drops, data stable while stalled.
REQ-041 Scenario: IFG_CYCLES=0, back-to-back 1-byte UDP frames -> no idle gap beyond the 1-cycle IDLE arbitration cycle, udp_frame_cnt_out increments each frame.
REQ-042 Scenario: logic_rst asserted at byte 20 of a 60-byte frame -> all outputs 0 immediately, FSM IDLE; after release a new ARP frame is forwarded intact.
REQ-043 Scenario: CNT_W=4, 17 ARP frames sent -> arp_frame_cnt_out=1 (counter wrap).
